dmem_block_responder: RTL and testbench
=======================================

Name: dmem_block_responder

Overview:
- Block-granular data memory that answers the data cache's miss/write-back interface.
- Accepts read-block and write-block requests (128-bit block, 28-bit block address), models a fixed multi-cycle access latency and stalls the cache via MEM_BUSYWAIT until the access completes.
- Sits between the data cache and the backing store on the RV32IM data path.

Parameters:
- BLOCK_W, 128, block width in bits (4 x 32-bit words, word 0 in bits [31:0]).
- ADDR_W, 28, block address width.
- DEPTH_LOG2, 8, log2 of stored blocks; only MEM_BLOCK_ADDR[DEPTH_LOG2-1:0] is decoded, upper bits are ignored (aliasing).
- ACCESS_CYCLES, 5, clock edges from request capture to completion; legal range 1..255.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- MEM_READ  input  1  block read request from cache, level, held until MEM_BUSYWAIT low is sampled.
- MEM_WRITE  input  1  block write request from cache, level, same rule.
- MEM_BLOCK_ADDR  input  ADDR_W  block address.
- MEM_WRITE_DATA  input  BLOCK_W  block to store.
- MEM_READ_DATA  output  BLOCK_W  fetched block, registered.
- MEM_BUSYWAIT  output  1  stall to cache.

Behaviour:
- Reset:
  - State goes to IDLE; counter 0; MEM_READ_DATA 0; MEM_BUSYWAIT 0 while RESET high.
  - Storage array is not cleared.
  - Reset mid-access abandons the access; no write commit.
- MEM_BUSYWAIT is combinational: (MEM_READ | MEM_WRITE) & (state != ACK) & ~RESET.
  - It rises in the same cycle the request appears, so the cache never samples low before capture.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If MEM_READ | MEM_WRITE at posedge, latch op, address and write data; counter = ACCESS_CYCLES-1; go to ACCESS.
  - If ACCESS_CYCLES == 1, go directly to ACK and perform the commit (see ACCESS) at this same edge.
- ACCESS:
  - Counter decrements each posedge.
  - At the posedge where counter == 0:
    - write: array[addr] = latched data.
    - read: MEM_READ_DATA = array[addr].
    - Go to ACK.
  - Completion edge = capture edge + ACCESS_CYCLES.
- ACK:
  - One cycle; MEM_BUSYWAIT low; then go to IDLE unconditionally.
  - A request still asserted in IDLE starts a new access, which covers the cache's write-back followed by refill with no idle gap required.
- Latched values are used for the whole access. Changes to address, op or data during ACCESS are ignored.
- Request drop during ACCESS (both MEM_READ and MEM_WRITE low at a posedge):
  - Abort to IDLE.
  - No write commit; MEM_READ_DATA unchanged.
- MEM_READ and MEM_WRITE both high at capture: write wins; treated as a write.
- MEM_READ_DATA holds its value until the next read completion.
- A read after a write to the same address returns the newly written block.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports RD_COUNT[31:0] and WR_COUNT[31:0].
  - Each counter increments by 1 on every completed (non-aborted) read or write respectively.
  - Counters wrap at 2^32 and reset to 0 on RESET.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - Localparams BLOCK_W = 128, ADDR_W = 28.
  - State enum {IDLE, ACCESS, ACK} as 2-bit encoding 00/01/10.
  - Shared with the data cache for its block-width constants.
- Sub-module dmem_array:
  - 2^DEPTH_LOG2 x BLOCK_W storage.
  - Synchronous write-enable port and registered read port, driven by the responder FSM.
  - No reset.

Test Plan:
- Reset, then write block 0x1111_2222_3333_4444_5555_6666_7777_8888 to addr 0x3, ACCESS_CYCLES=5 -> MEM_BUSYWAIT high in the request cycle, low exactly in the 6th cycle after capture (ACK), then low in IDLE once the request drops.
- Read addr 0x3 after the above -> MEM_READ_DATA equals the written block at the completion edge (capture + 5); MEM_BUSYWAIT low for exactly one cycle.
- Write-back then refill back-to-back: MEM_WRITE addr 0x10 held; after ACK the cache switches to MEM_READ addr 0x20 with no gap -> second access captured in the IDLE cycle; total stall 2 x (5+1)+1 cycles; addr 0x10 holds the new data.
- Abort: MEM_WRITE addr 0x5 dropped after 2 cycles of ACCESS -> state back to IDLE, a later read of 0x5 returns the old content, and WR_COUNT (with DMEM_ACCESS_COUNT_EN) is unchanged.
- Async RESET pulse mid-ACCESS of a write -> MEM_BUSYWAIT 0 immediately, MEM_READ_DATA 0, no commit; ACCESS_CYCLES=1 variant completes a read in ACK one edge after capture.
- Aliasing and priority: write to addr 0x100 with DEPTH_LOG2=8, then read addr 0x000 -> returns the same block; MEM_READ and MEM_WRITE asserted together -> performs a write.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the block-granular data memory.
// Also consumed by the data cache for its block-width constants.
package dmem_pkg;

    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Block storage: synchronous write port and registered read port sharing one address.
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int BLOCK_W    = 128
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [BLOCK_W-1:0]    wr_data,
    output logic [BLOCK_W-1:0]    rd_data
);

    logic [BLOCK_W-1:0] mem_r [2**DEPTH_LOG2];

    // Storage write and registered read, both qualified by the responder's commit strobes
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[addr];
        end
    end

endmodule

// File: rtl/dmem_block_responder.sv
// Fixed-latency block memory answering the data cache miss/write-back handshake.
// Optional access counters are enabled with `define DMEM_ACCESS_COUNT_EN.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2    = 8,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MEM_READ,
    input  logic               MEM_WRITE,
    input  logic [ADDR_W-1:0]  MEM_BLOCK_ADDR,
    input  logic [BLOCK_W-1:0] MEM_WRITE_DATA,
    output logic [BLOCK_W-1:0] MEM_READ_DATA,
`ifdef DMEM_ACCESS_COUNT_EN
    output logic [31:0]        RD_COUNT,
    output logic [31:0]        WR_COUNT,
`endif
    output logic               MEM_BUSYWAIT
);

    localparam logic [7:0] CNT_LOAD  = 8'(ACCESS_CYCLES - 1);
    localparam logic       ONE_CYCLE = (ACCESS_CYCLES == 1);

    state_e                  state_r;
    logic [7:0]              cnt_r;
    logic                    op_wr_r;
    logic [DEPTH_LOG2-1:0]   addr_r;
    logic [BLOCK_W-1:0]      wdata_r;
    logic                    rd_valid_r;

    logic                    req_s;
    logic                    commit_s;
    logic                    commit_wr_s;
    logic                    arr_we_s;
    logic                    arr_re_s;
    logic [DEPTH_LOG2-1:0]   arr_addr_s;
    logic [BLOCK_W-1:0]      arr_wdata_s;
    logic [BLOCK_W-1:0]      arr_rdata_s;

    assign req_s        = MEM_READ | MEM_WRITE;
    // Rises with the request so the cache cannot sample low before capture
    assign MEM_BUSYWAIT = req_s & (state_r != ST_ACK) & ~RESET;

    // Commit decode: in IDLE a single-cycle access commits straight from the live inputs
    always_comb begin
        arr_addr_s  = addr_r;
        arr_wdata_s = wdata_r;
        commit_wr_s = op_wr_r;
        commit_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            arr_addr_s  = MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
            arr_wdata_s = MEM_WRITE_DATA;
            commit_wr_s = MEM_WRITE;
            commit_s    = ONE_CYCLE & req_s;
        end else if (state_r == ST_ACCESS) begin
            commit_s    = req_s & (cnt_r == 8'd0);
        end else begin
            commit_s    = 1'b0;
        end
    end

    assign arr_we_s = commit_s & commit_wr_s & ~RESET;
    assign arr_re_s = commit_s & ~commit_wr_s & ~RESET;

    // Read data register is not resettable, so a valid flag forces zero until the first read
    assign MEM_READ_DATA = rd_valid_r ? arr_rdata_s : {BLOCK_W{1'b0}};

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BLOCK_W    (BLOCK_W)
    ) u_array (
        .CLK     (CLK),
        .wr_en   (arr_we_s),
        .rd_en   (arr_re_s),
        .addr    (arr_addr_s),
        .wr_data (arr_wdata_s),
        .rd_data (arr_rdata_s)
    );

    // Access sequencer: capture, count down, commit, one-cycle acknowledge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            op_wr_r    <= 1'b0;
            addr_r     <= {DEPTH_LOG2{1'b0}};
            wdata_r    <= {BLOCK_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        op_wr_r <= MEM_WRITE;
                        addr_r  <= MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
                        wdata_r <= MEM_WRITE_DATA;
                        cnt_r   <= CNT_LOAD;
                        state_r <= ONE_CYCLE ? ST_ACK : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == 8'd0) begin
                        state_r <= ST_ACK;
                    end else begin
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (arr_re_s) begin
                rd_valid_r <= 1'b1;
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    // Completed-access counters; aborted accesses never raise a commit strobe
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RD_COUNT <= 32'd0;
            WR_COUNT <= 32'd0;
        end else begin
            if (arr_re_s) begin
                RD_COUNT <= RD_COUNT + 32'd1;
            end
            if (arr_we_s) begin
                WR_COUNT <= WR_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed and randomized bench for dmem_block_responder (5-cycle and 1-cycle instances).
// Counter checks are compiled in when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_block_responder;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         rd0, wr0, rd1, wr1;
    logic [27:0]  a0, a1;
    logic [127:0] wd0, wd1;
    logic [127:0] rdata0, rdata1;
    logic         busy0, busy1;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0]  rc0, wc0, rc1, wc1;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: block contents keyed by instance*256 + decoded index
    logic [127:0] mem_m [int];
    logic [127:0] exp_rd [2];
    int           rd_cnt_m [2];
    int           wr_cnt_m [2];

    always #5 CLK = ~CLK;

    dmem_block_responder #(.DEPTH_LOG2(8), .ACCESS_CYCLES(5)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (rd0),
        .MEM_WRITE      (wr0),
        .MEM_BLOCK_ADDR (a0),
        .MEM_WRITE_DATA (wd0),
        .MEM_READ_DATA  (rdata0),
`ifdef DMEM_ACCESS_COUNT_EN
        .RD_COUNT       (rc0),
        .WR_COUNT       (wc0),
`endif
        .MEM_BUSYWAIT   (busy0)
    );

    dmem_block_responder #(.DEPTH_LOG2(8), .ACCESS_CYCLES(1)) dut1 (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (rd1),
        .MEM_WRITE      (wr1),
        .MEM_BLOCK_ADDR (a1),
        .MEM_WRITE_DATA (wd1),
        .MEM_READ_DATA  (rdata1),
`ifdef DMEM_ACCESS_COUNT_EN
        .RD_COUNT       (rc1),
        .WR_COUNT       (wc1),
`endif
        .MEM_BUSYWAIT   (busy1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [27:0] addr, input logic [127:0] data);
        if (sel) begin
            rd1 = rd; wr1 = wr; a1 = addr; wd1 = data;
        end else begin
            rd0 = rd; wr0 = wr; a0 = addr; wd0 = data;
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic [127:0] rdata_of(input bit sel);
        return sel ? rdata1 : rdata0;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One cache transaction; called just after a rising edge, returns edges counted
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [27:0] addr, input logic [127:0] data,
                          input bit chained, input bit drop, output int edges);
        int ac, exp_edges, n, key;
        ac        = sel ? 1 : 5;
        exp_edges = (ac == 1) ? 1 : ac + 1;
        key       = int'(sel) * 256 + int'(addr[7:0]);
        edges     = 0;
        drive(sel, rd, wr, addr, data);
        #1;
        if (chained) begin
            check("ack_cycle_busy", 128'(busy_of(sel)), 128'd0);
            @(posedge CLK); #1;
            edges++;
        end
        check("req_cycle_busy", 128'(busy_of(sel)), 128'd1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            n++;
            if (!busy_of(sel)) break;
        end
        edges += n;
        check("stall_edges", 128'(n), 128'(exp_edges));
        if (wr) begin
            mem_m[key] = data;
            wr_cnt_m[sel]++;
        end else begin
            exp_rd[sel] = mem_m[key];
            rd_cnt_m[sel]++;
        end
        check("read_data", rdata_of(sel), exp_rd[sel]);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rd_count", 128'(sel ? rc1 : rc0), 128'(rd_cnt_m[sel]));
        check("wr_count", 128'(sel ? wc1 : wc0), 128'(wr_cnt_m[sel]));
`endif
        if (drop) begin
            drive(sel, 1'b0, 1'b0, addr, data);
            @(posedge CLK); #1;
            check("idle_busy", 128'(busy_of(sel)), 128'd0);
        end
    endtask

    initial begin
        int e, e1, e2, key;
        logic [27:0]  addr;
        logic [127:0] blk_a, blk_b, blk_old, blk_new;
        bit sel, rd, wr;

        exp_rd   = '{128'd0, 128'd0};
        rd_cnt_m = '{0, 0};
        wr_cnt_m = '{0, 0};
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 28'd0, 128'd0);
        drive(1'b1, 1'b0, 1'b0, 28'd0, 128'd0);

        // Busywait is held low by reset even with a request present
        #2;
        rd0 = 1'b1; wr1 = 1'b1;
        #1;
        check("reset_busy0", 128'(busy0), 128'd0);
        check("reset_busy1", 128'(busy1), 128'd0);
        check("reset_rdata0", rdata0, 128'd0);
        check("reset_rdata1", rdata1, 128'd0);
        rd0 = 1'b0; wr1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Basic write then read of the same block
        access(1'b0, 1'b0, 1'b1, 28'h3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b1, e);
        access(1'b0, 1'b1, 1'b0, 28'h3, 128'd0, 1'b0, 1'b1, e);

        // Write-back followed by refill with no idle gap
        blk_a = rand_blk();
        blk_b = rand_blk();
        access(1'b0, 1'b0, 1'b1, 28'h20, blk_a, 1'b0, 1'b1, e);
        access(1'b0, 1'b0, 1'b1, 28'h10, blk_b, 1'b0, 1'b0, e1);
        access(1'b0, 1'b1, 1'b0, 28'h20, 128'd0, 1'b1, 1'b1, e2);
        check("b2b_total_edges", 128'(e1 + e2), 128'd13);
        access(1'b0, 1'b1, 1'b0, 28'h10, 128'd0, 1'b0, 1'b1, e);

        // Abort a write after two ACCESS edges
        blk_old = rand_blk();
        blk_new = ~blk_old;
        access(1'b0, 1'b0, 1'b1, 28'h5, blk_old, 1'b0, 1'b1, e);
        drive(1'b0, 1'b0, 1'b1, 28'h5, blk_new);
        repeat (3) @(posedge CLK);
        #1 drive(1'b0, 1'b0, 1'b0, 28'h5, blk_new);
        @(posedge CLK); #1;
        access(1'b0, 1'b1, 1'b0, 28'h5, 128'd0, 1'b0, 1'b1, e);

        // Asynchronous reset in the middle of a write
        blk_old = rand_blk();
        blk_new = ~blk_old;
        access(1'b0, 1'b0, 1'b1, 28'h7, blk_old, 1'b0, 1'b1, e);
        drive(1'b0, 1'b0, 1'b1, 28'h7, blk_new);
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("midreset_busy", 128'(busy0), 128'd0);
        check("midreset_rdata", rdata0, 128'd0);
        exp_rd   = '{128'd0, 128'd0};
        rd_cnt_m = '{0, 0};
        wr_cnt_m = '{0, 0};
        #1 RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 28'h7, blk_new);
        repeat (8) @(posedge CLK);
        #1;
        check("post_reset_rdata", rdata0, 128'd0);
        access(1'b0, 1'b1, 1'b0, 28'h7, 128'd0, 1'b0, 1'b1, e);

        // Single-cycle instance
        access(1'b1, 1'b0, 1'b1, 28'h9, rand_blk(), 1'b0, 1'b1, e);
        access(1'b1, 1'b1, 1'b0, 28'h9, 128'd0, 1'b0, 1'b1, e);

        // Address aliasing and write-over-read priority
        access(1'b0, 1'b0, 1'b1, 28'h100, rand_blk(), 1'b0, 1'b1, e);
        access(1'b0, 1'b1, 1'b0, 28'h000, 128'd0, 1'b0, 1'b1, e);
        access(1'b0, 1'b1, 1'b1, 28'h42, rand_blk(), 1'b0, 1'b1, e);
        access(1'b0, 1'b1, 1'b0, 28'h42, 128'd0, 1'b0, 1'b1, e);

        // Randomized traffic over a small index set with random upper address bits
        for (int i = 0; i < 30; i++) begin
            sel  = 1'($urandom_range(0, 1));
            addr = {20'($urandom()), 8'($urandom_range(0, 7))};
            key  = int'(sel) * 256 + int'(addr[7:0]);
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if (!mem_m.exists(key)) begin
                wr = 1'b1;
            end
            if (!rd && !wr) begin
                rd = 1'b1;
            end
            access(sel, rd, wr, addr, rand_blk(), 1'b0, 1'b1, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
